stream_mux_rr: RTL and testbench

Parametrised N-channel streaming multiplexer with valid/ready handshakes on every input and on the output, and a registered output stage. It supersedes select-driven combinational muxing where several producers share one consumer, for example datapath channels feeding one result bus. Source selection is by internal round-robin arbitration, not an external select. The output carries the index of the source of each beat.

---
 rtl/stream_mux_rr.sv | 110 +++++++++++
 tb/tb_stream_mux_rr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with round-robin arbitration
// and a single registered output stage. out_sel reports the source channel of each beat.
// Optional packet lock is enabled by defining STREAM_MUX_LOCK_EN; without it arbitration
// is per beat and in_last is only passed through.
module stream_mux_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 16,
    localparam int unsigned SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_sel,
    output logic                 out_last
);

    logic             load;
    logic [SW-1:0]    ptr_q;
    logic [NCH-1:0]   cand;
    logic [NCH-1:0]   grant;
    logic             found;
    logic [SW-1:0]    gidx;
    logic [WIDTH-1:0] gdata;
    logic             glast;

    // The output register can take a new beat when empty or being drained this cycle.
    assign load = !out_valid || out_ready;

`ifdef STREAM_MUX_LOCK_EN
    logic lock_q;

    // While a packet is open only its channel (held in ptr_q) may compete.
    always_comb begin
        cand = in_valid;
        if (lock_q) begin
            cand = in_valid & (NCH'(1) << ptr_q);
        end
    end
`else
    assign cand = in_valid;
`endif

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int unsigned   idx;
        logic [SW-1:0] idx_s;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        idx_s = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx   = (32'(ptr_q) + k) % NCH;
            idx_s = SW'(idx);
            if (!found && cand[idx_s]) begin
                found = 1'b1;
                gidx  = idx_s;
            end
        end
    end

    assign grant    = found ? (NCH'(1) << gidx) : '0;
    assign in_ready = load ? grant : '0;

    // Select the granted channel's payload; grant is one-hot so OR-reduction is exact.
    always_comb begin
        gdata = '0;
        glast = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gdata = gdata | in_data[i*WIDTH +: WIDTH];
                glast = glast | in_last[i];
            end
        end
    end

    // Output register, round-robin pointer and (optionally) packet lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            ptr_q     <= SW'(NCH - 1);
`ifdef STREAM_MUX_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_sel   <= gidx;
                out_last  <= glast;
                ptr_q     <= gidx;
`ifdef STREAM_MUX_LOCK_EN
                // Only the locked channel can win while locked, so its last beat unlocks.
                lock_q    <= !glast;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: table-driven cycles on a 16-channel instance with a beat
// scoreboard, plus a hand-written wrap sequence on a 5-channel instance.
module tb_stream_mux_rr;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  in_valid;
    logic [15:0]  in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_last;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_sel;
    logic         out_last;

    logic [4:0]   v5;
    logic [4:0]   rdy5;
    logic [39:0]  d5;
    logic         ov5;
    logic [7:0]   od5;
    logic [2:0]   os5;
    logic         ol5;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(8), .NCH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last)
    );

    stream_mux_rr #(.WIDTH(8), .NCH(5)) dut5 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v5),
        .in_ready  (rdy5),
        .in_data   (d5),
        .in_last   (5'h1f),
        .out_valid (ov5),
        .out_ready (1'b1),
        .out_data  (od5),
        .out_sel   (os5),
        .out_last  (ol5)
    );

    typedef struct {
        logic [15:0] v;
        logic [15:0] last;
        logic        ordy;
        logic [15:0] rdy;
        logic        ov;
    } vec_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    vec_t       tbl[$];
    beat_t      sb[$];
    logic [7:0] chan_dat[16];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic vec_t mk(logic [15:0] v, logic [15:0] last, logic ordy,
                                logic [15:0] rdy, logic ov);
        vec_t r;
        r.v = v; r.last = last; r.ordy = ordy; r.rdy = rdy; r.ov = ov;
        return r;
    endfunction

    function automatic int oh2i(logic [15:0] oh);
        for (int i = 0; i < 16; i++) if (oh[i]) return i;
        return -1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '1;
        out_ready = 1'b1;
        v5        = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_sel",   64'(out_sel),   64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        sb.delete();
    endtask

    task automatic run_tbl(string tag);
        beat_t b;
        for (int n = 0; n < tbl.size(); n++) begin
            @(negedge clk);
            in_valid  = tbl[n].v;
            in_last   = tbl[n].last;
            out_ready = tbl[n].ordy;
            for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = chan_dat[i];
            #1;
            chk({tag, "_in_ready"}, 64'(in_ready), 64'(tbl[n].rdy));
            chk({tag, "_out_valid"}, 64'(out_valid), 64'(tbl[n].ov));
            if (tbl[n].ov) begin
                if (sb.size() == 0) begin
                    chk({tag, "_sb_empty"}, 64'(1), 64'(0));
                end else begin
                    chk({tag, "_out_sel"},  64'(out_sel),  64'(sb[0].sel));
                    chk({tag, "_out_data"}, 64'(out_data), 64'(sb[0].data));
                    chk({tag, "_out_last"}, 64'(out_last), 64'(sb[0].last));
                    if (tbl[n].ordy) void'(sb.pop_front());
                end
            end
            if (tbl[n].rdy != 0) begin
                b.sel  = oh2i(tbl[n].rdy);
                b.data = chan_dat[b.sel];
                b.last = tbl[n].last[b.sel];
                sb.push_back(b);
            end
        end
        chk({tag, "_sb_drained"}, 64'(sb.size()), 64'(0));
        tbl.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '1;
        in_data   = '0;
        out_ready = 1'b1;
        v5        = '0;
        for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'(8'h30 + i);
        for (int i = 0; i < 16; i++) chan_dat[i] = 8'(i);

        // Single source: ch5 carrying 0xA5.
        do_reset();
        chan_dat[5] = 8'hA5;
        tbl.push_back(mk(16'h0020, 16'hffff, 1'b1, 16'h0020, 1'b0));
        tbl.push_back(mk(16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b1));
        tbl.push_back(mk(16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b0));
        run_tbl("single");

        // Rotation among ch0, ch3, ch15 with no idle cycles.
        do_reset();
        for (int i = 0; i < 16; i++) chan_dat[i] = 8'(i);
        tbl.push_back(mk(16'h8009, 16'hffff, 1'b1, 16'h0001, 1'b0));
        tbl.push_back(mk(16'h8009, 16'hffff, 1'b1, 16'h0008, 1'b1));
        tbl.push_back(mk(16'h8009, 16'hffff, 1'b1, 16'h8000, 1'b1));
        tbl.push_back(mk(16'h8009, 16'hffff, 1'b1, 16'h0001, 1'b1));
        tbl.push_back(mk(16'h8009, 16'hffff, 1'b1, 16'h0008, 1'b1));
        tbl.push_back(mk(16'h8009, 16'hffff, 1'b1, 16'h8000, 1'b1));
        tbl.push_back(mk(16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b1));
        tbl.push_back(mk(16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b0));
        run_tbl("rotate");

        // Backpressure: ch2 beat held for 4 stalled cycles, ch4 follows without a bubble.
        do_reset();
        chan_dat[2] = 8'h11;
        chan_dat[4] = 8'h44;
        tbl.push_back(mk(16'h0014, 16'hffff, 1'b1, 16'h0004, 1'b0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(16'h0010, 16'hffff, 1'b0, 16'h0000, 1'b1));
        tbl.push_back(mk(16'h0010, 16'hffff, 1'b1, 16'h0010, 1'b1));
        tbl.push_back(mk(16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b1));
        tbl.push_back(mk(16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b0));
        run_tbl("bkpr");

        // Packet of three beats on ch1 while ch2 stays valid.
        do_reset();
        chan_dat[1] = 8'h01;
        chan_dat[2] = 8'h02;
`ifdef STREAM_MUX_LOCK_EN
        tbl.push_back(mk(16'h0006, 16'h0004, 1'b1, 16'h0002, 1'b0));
        tbl.push_back(mk(16'h0006, 16'h0004, 1'b1, 16'h0002, 1'b1));
        tbl.push_back(mk(16'h0006, 16'h0006, 1'b1, 16'h0002, 1'b1));
        tbl.push_back(mk(16'h0004, 16'h0006, 1'b1, 16'h0004, 1'b1));
        tbl.push_back(mk(16'h0000, 16'h0006, 1'b1, 16'h0000, 1'b1));
        tbl.push_back(mk(16'h0000, 16'h0006, 1'b1, 16'h0000, 1'b0));
`else
        tbl.push_back(mk(16'h0006, 16'h0004, 1'b1, 16'h0002, 1'b0));
        tbl.push_back(mk(16'h0006, 16'h0004, 1'b1, 16'h0004, 1'b1));
        tbl.push_back(mk(16'h0006, 16'h0004, 1'b1, 16'h0002, 1'b1));
        tbl.push_back(mk(16'h0006, 16'h0006, 1'b1, 16'h0004, 1'b1));
        tbl.push_back(mk(16'h0006, 16'h0006, 1'b1, 16'h0002, 1'b1));
        tbl.push_back(mk(16'h0000, 16'h0006, 1'b1, 16'h0000, 1'b1));
        tbl.push_back(mk(16'h0000, 16'h0006, 1'b1, 16'h0000, 1'b0));
`endif
        run_tbl("lock");

        // Five channels, all valid from reset: grants 0..4 then wrap to 0.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            logic [4:0] e;
            @(negedge clk);
            v5 = 5'h1f;
            #1;
            e = 5'(5'd1 << (k % 5));
            chk("nch5_in_ready", 64'(rdy5), 64'(e));
            if (k > 0) begin
                chk("nch5_out_valid", 64'(ov5), 64'(1));
                chk("nch5_out_sel",   64'(os5), 64'((k - 1) % 5));
                chk("nch5_out_data",  64'(od5), 64'(8'h30 + (k - 1) % 5));
            end
        end
        @(negedge clk);
        v5 = '0;
        #1;
        chk("nch5_last_sel", 64'(os5), 64'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
